// File: rtl/gpio_wb.sv
// gpio_wb: Wishbone-classic GPIO block. It has synchronised key inputs,
// per-channel edge interrupts (status is write-1-to-clear) and registered
// LED outputs.
// Optional feature: define GPIO_DEBOUNCE_EN to add a per-channel debounce
// filter. The filter uses a DEB_W-bit counter and a DEB_MAX hold time.
// Register map (word address): 0 DATA_IN, 1 DATA_OUT, 2 IRQ_MASK,
// 3 IRQ_STATUS (W1C), 4 EDGE_SEL (1 = rising, 0 = falling), 5..7 read as 0.
module gpio_wb #(
    parameter int IN_W    = 4,
    parameter int OUT_W   = 4,
    parameter int DEB_MAX = 1000000,
    parameter int DEB_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic             wb_ack_o,
    input  logic [IN_W-1:0]  gpio_i,
    output logic [OUT_W-1:0] gpio_o,
    output logic             irq_o
);

    localparam logic [2:0] ADR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADR_MASK     = 3'd2;
    localparam logic [2:0] ADR_STATUS   = 3'd3;
    localparam logic [2:0] ADR_EDGE     = 3'd4;

    logic [IN_W-1:0]  sync1_q, sync2_q, stable_s, stable_dly_q;
    logic [IN_W-1:0]  mask_q, status_q, status_d, edge_sel_q;
    logic [IN_W-1:0]  rise_s, fall_s, edge_ev_s, w1c_s;
    logic [OUT_W-1:0] dout_q;
    logic             ack_q, irq_q, req_s, wr_s;
    logic [31:0]      dat_q, rdata_s;
    logic             unused_dat_s;

    // A new access starts only while ack is low, so a held strobe acks every other cycle.
    assign req_s        = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_s         = req_s & wb_we_i;
    assign unused_dat_s = ^wb_dat_i;

    // Two-flop synchroniser for the asynchronous key inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {IN_W{1'b0}};
            sync2_q <= {IN_W{1'b0}};
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_MAX - 1);
    localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(1);

    for (genvar g = 0; g < IN_W; g++) begin : g_deb
        logic [DEB_W-1:0] cnt_q;
        logic             stable_q;

        // Count cycles the input disagrees with the stable level; any agreement restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= {DEB_W{1'b0}};
                stable_q <= 1'b0;
            end else if (sync2_q[g] == stable_q) begin
                cnt_q    <= {DEB_W{1'b0}};
                stable_q <= stable_q;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q    <= {DEB_W{1'b0}};
                stable_q <= ~stable_q;
            end else begin
                cnt_q    <= cnt_q + CNT_ONE;
                stable_q <= stable_q;
            end
        end

        assign stable_s[g] = stable_q;
    end
`else
    assign stable_s = sync2_q;
`endif

    // Edge selection per channel, merged with W1C clears (a new edge wins over a clear).
    always_comb begin
        rise_s    = stable_s & ~stable_dly_q;
        fall_s    = ~stable_s & stable_dly_q;
        edge_ev_s = (edge_sel_q & rise_s) | (~edge_sel_q & fall_s);
        if (wr_s && (wb_adr_i == ADR_STATUS)) begin
            w1c_s = wb_dat_i[IN_W-1:0];
        end else begin
            w1c_s = {IN_W{1'b0}};
        end
        status_d = (status_q & ~w1c_s) | edge_ev_s;
    end

    // Read mux; unmapped addresses and bits above the channel width read as zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (wb_adr_i)
            ADR_DATA_IN:  rdata_s[IN_W-1:0]  = stable_s;
            ADR_DATA_OUT: rdata_s[OUT_W-1:0] = dout_q;
            ADR_MASK:     rdata_s[IN_W-1:0]  = mask_q;
            ADR_STATUS:   rdata_s[IN_W-1:0]  = status_q;
            ADR_EDGE:     rdata_s[IN_W-1:0]  = edge_sel_q;
            default:      rdata_s = 32'h0000_0000;
        endcase
    end

    // Bus handshake: read data and writes commit on the same edge that raises ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'h0000_0000;
            dout_q     <= {OUT_W{1'b0}};
            mask_q     <= {IN_W{1'b0}};
            edge_sel_q <= {IN_W{1'b0}};
        end else begin
            ack_q <= req_s;
            if (req_s) begin
                dat_q <= rdata_s;
            end else begin
                dat_q <= dat_q;
            end
            if (wr_s) begin
                case (wb_adr_i)
                    ADR_DATA_OUT: dout_q     <= wb_dat_i[OUT_W-1:0];
                    ADR_MASK:     mask_q     <= wb_dat_i[IN_W-1:0];
                    ADR_EDGE:     edge_sel_q <= wb_dat_i[IN_W-1:0];
                    default:      dout_q     <= dout_q;
                endcase
            end
        end
    end

    // Edge history, interrupt status and the registered interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_dly_q <= {IN_W{1'b0}};
            status_q     <= {IN_W{1'b0}};
            irq_q        <= 1'b0;
        end else begin
            stable_dly_q <= stable_s;
            status_q     <= status_d;
            irq_q        <= |(status_q & mask_q);
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign gpio_o   = dout_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_gpio_wb.sv
// Testbench for gpio_wb. A behavioural model is checked every cycle, and
// directed literal checks pin the model. Random bus, input and reset traffic
// follows. It works with GPIO_DEBOUNCE_EN either defined or undefined.
module tb_gpio_wb;
    localparam int DEB_MAX = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 2 + DEB_MAX;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  adr;
    logic [31:0] dat_i, dat_o;
    logic        we, stb, cyc, ack, irq;
    logic [3:0]  gpio_i, gpio_o;

    int n_cmp = 0;
    int n_bad = 0;

    gpio_wb #(.IN_W(4), .OUT_W(4), .DEB_MAX(DEB_MAX), .DEB_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hq[k-1] is the input value seen at clock edge k after reset.
    // sq[k] is the filtered level after edge k.
    logic [3:0]  hq[$];
    logic [3:0]  sq[$];
    logic        m_ack, m_irq;
    logic [31:0] m_dat;
    logic [3:0]  m_dout, m_mask, m_status, m_esel;

    function automatic logic [3:0] h(input int k);
        if (k >= 1 && k <= hq.size()) return hq[k-1];
        return 4'h0;
    endfunction

    function automatic logic [3:0] s(input int k);
        if (k >= 0 && k < sq.size()) return sq[k];
        return 4'h0;
    endfunction

    task automatic model_reset();
        hq.delete();
        sq.delete();
        sq.push_back(4'h0);
        m_ack = 1'b0; m_irq = 1'b0; m_dat = 32'h0;
        m_dout = 4'h0; m_mask = 4'h0; m_status = 4'h0; m_esel = 4'h0;
    endtask

    task automatic model_step();
        logic       req, flip;
        logic [3:0] cur, prv, nxt, hv, ev, w1c, rd;
        int         n;
        req = cyc & stb & ~m_ack;
        hq.push_back(gpio_i);
        n   = hq.size();
        cur = s(n - 1);
        prv = s(n - 2);
        nxt = cur;
`ifdef GPIO_DEBOUNCE_EN
        // A level flips only when the last DEB_MAX synchronised samples all disagree with it.
        for (int b = 0; b < 4; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DEB_MAX; j++) begin
                hv = h(n - 2 - j);
                if (hv[b] == cur[b]) flip = 1'b0;
            end
            nxt[b] = cur[b] ^ flip;
        end
`else
        flip = 1'b0;
        hv   = 4'h0;
        nxt  = h(n - 1);
`endif
        sq.push_back(nxt);
        ev  = (m_esel & cur & ~prv) | (~m_esel & ~cur & prv);
        w1c = (req && we && adr == 3'd3) ? dat_i[3:0] : 4'h0;
        case (adr)
            3'd0:    rd = cur;
            3'd1:    rd = m_dout;
            3'd2:    rd = m_mask;
            3'd3:    rd = m_status;
            3'd4:    rd = m_esel;
            default: rd = 4'h0;
        endcase
        m_irq    = |(m_status & m_mask);
        m_status = (m_status & ~w1c) | ev;
        if (req && we) begin
            if (adr == 3'd1) m_dout = dat_i[3:0];
            if (adr == 3'd2) m_mask = dat_i[3:0];
            if (adr == 3'd4) m_esel = dat_i[3:0];
        end
        if (req) m_dat = {28'h0, rd};
        m_ack = req;
    endtask

    // Model advance: runs on every clock edge and on reset assertion.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of all DUT outputs against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("ack_o", 32'(ack), 32'(m_ack));
            check("dat_o", dat_o, m_dat);
            check("gpio_o", 32'(gpio_o), 32'(m_dout));
            check("irq_o", 32'(irq), 32'(m_irq));
        end
    end

    // ---------------- directed helpers ----------------
    // Called just after a negedge. Returns the read data, whether ack came,
    // and how many edges it took.
    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic got, output int edges);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        got = 1'b0; edges = 0;
        while (!got && edges < 4) begin
            @(posedge clk);
            #1;
            edges++;
            if (ack) got = 1'b1;
        end
        r = dat_o;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] r; logic g; int e;
        bus(1'b0, a, 32'h0, r, g, e);
        check({nm, " ack"}, 32'(g), 32'd1);
        check(nm, r, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r; logic g; int e;
        bus(1'b1, a, d, r, g, e);
        check("write ack", 32'(g), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r; logic g; int e;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 3'd0;
        dat_i = 32'h0; gpio_i = 4'h0;
        repeat (3) @(negedge clk);
        check("reset gpio_o", 32'(gpio_o), 32'h0);
        check("reset ack_o", 32'(ack), 32'h0);
        check("reset irq_o", 32'(irq), 32'h0);
        check("reset dat_o", dat_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write DATA_OUT, then read it back.
        bus(1'b1, 3'd1, 32'h5, r, g, e);
        check("write ack latency", 32'(e), 32'd1);
        check("gpio_o after write", 32'(gpio_o), 32'h5);
        rd(3'd1, 32'h5, "read DATA_OUT");

        // Input latency and a short pulse.
        gpio_i = 4'h1;
        repeat (LAT - 1) @(negedge clk);
        rd(3'd0, 32'h0, "DATA_IN before latency");
        rd(3'd0, 32'h1, "DATA_IN after latency");
        gpio_i = 4'h3;
        repeat (3) @(negedge clk);
        gpio_i = 4'h1;
        repeat (12) @(negedge clk);
        rd(3'd0, 32'h1, "DATA_IN after short pulse");

        // Rising-edge interrupt and W1C.
        wr(3'd4, 32'h1);
        wr(3'd2, 32'h1);
        gpio_i = 4'h0;
        repeat (12) @(negedge clk);
        wr(3'd3, 32'hF);
        gpio_i = 4'h1;
        repeat (12) @(negedge clk);
        rd(3'd3, 32'h1, "STATUS after rise");
        check("irq after rise", 32'(irq), 32'd1);
        wr(3'd3, 32'h1);
        check("irq one cycle after clear edge", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq after clear", 32'(irq), 32'd0);
        rd(3'd3, 32'h0, "STATUS after clear");

        // A set on the same edge as a W1C clear leaves the bit at 1.
        gpio_i = 4'h0; repeat (12) @(negedge clk);
        gpio_i = 4'h1; repeat (12) @(negedge clk);
        rd(3'd3, 32'h1, "STATUS before collision");
        gpio_i = 4'h0; repeat (12) @(negedge clk);
        gpio_i = 4'h1;
        repeat (LAT) @(negedge clk);
        wr(3'd3, 32'h1);
        rd(3'd3, 32'h1, "STATUS set beats W1C");
        wr(3'd3, 32'h1);
        rd(3'd3, 32'h0, "STATUS cleared later");

        // Unmapped addresses and upper bits.
        rd(3'd6, 32'h0, "read addr 6");
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, 32'h0, "read addr 5");
        rd(3'd1, 32'h5, "DATA_OUT after addr 5 write");
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, 32'hF, "MASK upper bits");
        gpio_i = 4'hA;
        repeat (LAT - 1) @(negedge clk);
        rd(3'd0, 32'h1, "DATA_IN 0xA before latency");
        rd(3'd0, 32'hA, "DATA_IN 0xA after latency");

        // Reset during an active write.
        gpio_i = 4'h0;
        repeat (12) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; dat_i = 32'hF;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("no ack in reset", 32'(ack), 32'd0);
        check("gpio_o in reset", 32'(gpio_o), 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 5; a++) rd(3'(a), 32'h0, "read after reset");

        // Input held high through reset.
        gpio_i = 4'h1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        rd(3'd0, 32'h1, "DATA_IN high through reset");

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(5, 0) == 0) gpio_i = 4'($urandom);
            cyc   = ($urandom_range(3, 0) != 0);
            stb   = cyc & ($urandom_range(3, 0) != 0);
            we    = 1'($urandom_range(1, 0));
            adr   = 3'($urandom_range(7, 0));
            dat_i = $urandom;
            rst_n = ($urandom_range(399, 0) != 0);
            @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
